// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core / DMA / data-RAM signal bundle for dmem_arbiter
// core_err and dma_err exist only when DMEM_ARB_RANGE_CHECK_EN is defined.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              core_req;
  logic              core_we;
  logic [31:0]       core_addr;
  logic [31:0]       core_wdata;
  logic [31:0]       core_rdata;
  logic              core_stall;

  logic              dma_req;
  logic              dma_we;
  logic [31:0]       dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [31:0]       dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic              core_err;
  logic              dma_err;
`endif

  modport slave (
`ifdef DMEM_ARB_RANGE_CHECK_EN
    output core_err, dma_err,
`endif
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
`ifdef DMEM_ARB_RANGE_CHECK_EN
    input  core_err, dma_err,
`endif
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM arbiter: core priority, DMA starvation limit
// Optional DMEM_ARB_RANGE_CHECK_EN blocks out-of-range accesses and reports core_err/dma_err.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CORE_RESP, DMA_RESP} state_e;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  // Outstanding read was out of range and must return zero.
  logic        zero_rd_q, zero_rd_d;
  logic        dma_win;
  logic        gnt;
  logic        core_oor, dma_oor;
  logic [31:0] resp_data;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic        core_err_q, core_err_d;
  logic        unused_addr_bits;

  assign core_oor         = |bus.core_addr[31:ADDR_W+2];
  assign dma_oor          = |bus.dma_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^{bus.core_addr[1:0], bus.dma_addr[1:0]};
`else
  logic        unused_addr_bits;

  assign core_oor         = 1'b0;
  assign dma_oor          = 1'b0;
  assign unused_addr_bits = ^{bus.core_addr[31:ADDR_W+2], bus.core_addr[1:0],
                              bus.dma_addr[31:ADDR_W+2], bus.dma_addr[1:0]};
`endif

  assign dma_win   = bus.dma_req && (!bus.core_req || wait_cnt_q == WAIT_MAX);
  assign resp_data = zero_rd_q ? 32'h0 : bus.mem_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      rdata_q     <= 32'h0;
      dma_rdata_q <= 32'h0;
      zero_rd_q   <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
      core_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rdata_q     <= rdata_d;
      dma_rdata_q <= dma_rdata_d;
      zero_rd_q   <= zero_rd_d;
`ifdef DMEM_ARB_RANGE_CHECK_EN
      core_err_q  <= core_err_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    rdata_d        = rdata_q;
    dma_rdata_d    = dma_rdata_q;
    zero_rd_d      = zero_rd_q;
    gnt            = 1'b0;
    bus.core_stall = 1'b0;
    bus.core_rdata = rdata_q;
    bus.dma_gnt    = 1'b0;
    bus.dma_rvalid = 1'b0;
    bus.dma_rdata  = dma_rdata_q;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 32'h0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    core_err_d     = core_err_q;
    bus.dma_err    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Requests are ignored while reset is held so every output reads 0.
        if (rst_ni && dma_win) begin
          gnt            = 1'b1;
          bus.mem_en     = !dma_oor;
          bus.mem_we     = bus.dma_we && !dma_oor;
          bus.mem_addr   = bus.dma_addr[ADDR_W+1:2];
          bus.mem_wdata  = bus.dma_wdata;
          bus.core_stall = bus.core_req;
`ifdef DMEM_ARB_RANGE_CHECK_EN
          bus.dma_err    = dma_oor;
`endif
          if (!bus.dma_we) begin
            state_d   = DMA_RESP;
            zero_rd_d = dma_oor;
          end
        end else if (rst_ni && bus.core_req) begin
          bus.mem_en     = !core_oor;
          bus.mem_we     = bus.core_we && !core_oor;
          bus.mem_addr   = bus.core_addr[ADDR_W+1:2];
          bus.mem_wdata  = bus.core_wdata;
          bus.core_stall = !bus.core_we;
`ifdef DMEM_ARB_RANGE_CHECK_EN
          core_err_d     = core_err_q || core_oor;
`endif
          if (!bus.core_we) begin
            state_d   = CORE_RESP;
            zero_rd_d = core_oor;
          end
        end
      end
      CORE_RESP: begin
        bus.core_rdata = resp_data;
        rdata_d        = resp_data;
        state_d        = IDLE;
      end
      DMA_RESP: begin
        bus.dma_rvalid = 1'b1;
        bus.dma_rdata  = resp_data;
        dma_rdata_d    = resp_data;
        bus.core_stall = bus.core_req;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bus.dma_gnt = gnt;

    // Counts blocked DMA cycles, including cycles spent in a response state.
    if (!bus.dma_req || gnt)
      wait_cnt_d = 4'd0;
    else if (wait_cnt_q != WAIT_MAX)
      wait_cnt_d = wait_cnt_q + 4'd1;
    else
      wait_cnt_d = wait_cnt_q;
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign bus.core_err = core_err_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
// Range-check steps run only when DMEM_ARB_RANGE_CHECK_EN is defined.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 10;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Synchronous single-port RAM model
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic [31:0] ram_rdata = 32'h0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_rdata <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_rdata;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] shadow [int];
  logic [31:0] core_q[$];
  logic [31:0] dma_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs, input bit is_dma);
    logic [31:0] e;
    if (is_dma ? dma_q.size() == 0 : core_q.size() == 0) begin
      nvec++;
      nerr++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
    end else begin
      e = is_dma ? dma_q.pop_front() : core_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 32'h0; bus.core_wdata = 32'h0;
    bus.dma_req  = 1'b0; bus.dma_we  = 1'b0; bus.dma_addr  = 32'h0; bus.dma_wdata  = 32'h0;
  endtask

  task automatic core_drv(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
  endtask

  task automatic dma_drv(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  initial begin
    idle_in();
    // Reset state, with both requests asserted during reset
    bus.core_req = 1'b1;
    bus.dma_req  = 1'b1;
    mid();
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_stall", bus.core_stall, 0);
    check("rst_gnt", bus.dma_gnt, 0);
    check("rst_rvalid", bus.dma_rvalid, 0);
    check("rst_core_rdata", bus.core_rdata, 0);
    check("rst_dma_rdata", bus.dma_rdata, 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    idle_in();
    tick();
    rst_n = 1'b1;

    // Core store then load
    core_drv(1'b1, 32'h10, 32'hDEADBEEF);
    shadow[4] = 32'hDEADBEEF;
    mid();
    check("st_mem_en", bus.mem_en, 1);
    check("st_mem_we", bus.mem_we, 1);
    check("st_mem_addr", 32'(bus.mem_addr), 4);
    check("st_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("st_stall", bus.core_stall, 0);
    tick();
    core_drv(1'b0, 32'h10, 32'h0);
    core_q.push_back(shadow[4]);
    mid();
    check("ld_mem_en", bus.mem_en, 1);
    check("ld_mem_we", bus.mem_we, 0);
    check("ld_stall", bus.core_stall, 1);
    tick();
    mid();
    check("ld_resp_stall", bus.core_stall, 0);
    check("ld_resp_no_issue", bus.mem_en, 0);
    pop_check("ld_rdata", bus.core_rdata, 1'b0);
    tick();
    idle_in();
    mid();
    check("ld_rdata_held", bus.core_rdata, 32'hDEADBEEF);
    check("idle_mem_en", bus.mem_en, 0);
    tick();

    // DMA write then read with core idle
    dma_drv(1'b1, 32'h40, 32'h12345678);
    shadow[16] = 32'h12345678;
    mid();
    check("dw_gnt", bus.dma_gnt, 1);
    check("dw_mem_we", bus.mem_we, 1);
    check("dw_mem_addr", 32'(bus.mem_addr), 16);
    check("dw_stall", bus.core_stall, 0);
    tick();
    dma_drv(1'b0, 32'h40, 32'h0);
    dma_q.push_back(shadow[16]);
    mid();
    check("dr_gnt", bus.dma_gnt, 1);
    check("dr_rvalid_early", bus.dma_rvalid, 0);
    tick();
    idle_in();
    mid();
    check("dr_rvalid", bus.dma_rvalid, 1);
    pop_check("dr_rdata", bus.dma_rdata, 1'b1);
    tick();
    mid();
    check("dr_rvalid_pulse", bus.dma_rvalid, 0);
    check("dr_rdata_held", bus.dma_rdata, 32'h12345678);
    tick();

    // Back-to-back core loads: one every two cycles
    core_drv(1'b0, 32'h40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      mid();
      check($sformatf("b2b_stall_%0d", k), bus.core_stall, (k % 2 == 0) ? 1 : 0);
      check($sformatf("b2b_en_%0d", k), bus.mem_en, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) core_q.push_back(shadow[16]);
      else pop_check($sformatf("b2b_rdata_%0d", k), bus.core_rdata, 1'b0);
      tick();
    end

    // Starvation: core stores every cycle, DMA write wins after MAX_WAIT blocked cycles
    core_drv(1'b1, 32'h100, 32'h11111111);
    dma_drv(1'b1, 32'h200, 32'hA5A5A5A5);
    shadow[64]  = 32'h11111111;
    shadow[128] = 32'hA5A5A5A5;
    for (int k = 0; k <= MAX_WAIT; k++) begin
      mid();
      check($sformatf("sv_gnt_%0d", k), bus.dma_gnt, (k == MAX_WAIT) ? 1 : 0);
      check($sformatf("sv_stall_%0d", k), bus.core_stall, (k == MAX_WAIT) ? 1 : 0);
      check($sformatf("sv_addr_%0d", k), 32'(bus.mem_addr), (k == MAX_WAIT) ? 128 : 64);
      tick();
    end

    // Counter restarts after grant; core load collides with starved DMA read
    dma_drv(1'b0, 32'h40, 32'h0);
    for (int k = 0; k < MAX_WAIT; k++) begin
      mid();
      check($sformatf("sv2_gnt_%0d", k), bus.dma_gnt, 0);
      tick();
    end
    core_drv(1'b0, 32'h10, 32'h0);
    dma_q.push_back(shadow[16]);
    mid();
    check("col_gnt", bus.dma_gnt, 1);
    check("col_stall0", bus.core_stall, 1);
    check("col_addr0", 32'(bus.mem_addr), 16);
    tick();
    bus.dma_req = 1'b0;
    core_q.push_back(shadow[4]);
    mid();
    check("col_rvalid", bus.dma_rvalid, 1);
    check("col_stall1", bus.core_stall, 1);
    pop_check("col_dma_rdata", bus.dma_rdata, 1'b1);
    tick();
    mid();
    check("col_stall2", bus.core_stall, 1);
    check("col_addr2", 32'(bus.mem_addr), 4);
    tick();
    mid();
    check("col_stall3", bus.core_stall, 0);
    pop_check("col_core_rdata", bus.core_rdata, 1'b0);
    tick();
    idle_in();

    // Read back the starvation-cycle writes through the DMA port
    dma_drv(1'b0, 32'h200, 32'h0);
    dma_q.push_back(shadow[128]);
    tick();
    bus.dma_req = 1'b0;
    mid();
    pop_check("rb_dma_win", bus.dma_rdata, 1'b1);
    tick();
    dma_drv(1'b0, 32'h100, 32'h0);
    dma_q.push_back(shadow[64]);
    tick();
    bus.dma_req = 1'b0;
    mid();
    pop_check("rb_core_st", bus.dma_rdata, 1'b1);
    tick();

    // Reset during CORE_RESP
    core_drv(1'b0, 32'h10, 32'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rcr_stall", bus.core_stall, 0);
    check("rcr_rdata", bus.core_rdata, 0);
    check("rcr_mem_en", bus.mem_en, 0);
    idle_in();
    tick();
    rst_n = 1'b1;

    // Reset during DMA_RESP
    dma_drv(1'b0, 32'h40, 32'h0);
    mid();
    check("rdr_gnt", bus.dma_gnt, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rdr_rvalid", bus.dma_rvalid, 0);
    check("rdr_rdata", bus.dma_rdata, 0);
    idle_in();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mid();
      check($sformatf("rdr_post_rvalid_%0d", k), bus.dma_rvalid, 0);
      tick();
    end

    // FSM back in IDLE: a core load issues immediately
    core_drv(1'b0, 32'h10, 32'h0);
    core_q.push_back(shadow[4]);
    mid();
    check("post_rst_en", bus.mem_en, 1);
    check("post_rst_stall", bus.core_stall, 1);
    tick();
    idle_in();
    mid();
    pop_check("post_rst_rdata", bus.core_rdata, 1'b0);
    tick();

`ifdef DMEM_ARB_RANGE_CHECK_EN
    check("rc_err_clear", bus.core_err, 0);
    core_drv(1'b0, 32'h8000_0000, 32'h0);
    mid();
    check("rc_mem_en", bus.mem_en, 0);
    check("rc_stall", bus.core_stall, 1);
    tick();
    mid();
    check("rc_rdata", bus.core_rdata, 0);
    check("rc_err", bus.core_err, 1);
    tick();
    idle_in();
    dma_drv(1'b0, 32'h0001_0000, 32'h0);
    mid();
    check("rc_dma_gnt", bus.dma_gnt, 1);
    check("rc_dma_err", bus.dma_err, 1);
    check("rc_dma_en", bus.mem_en, 0);
    tick();
    idle_in();
    mid();
    check("rc_dma_rvalid", bus.dma_rvalid, 1);
    check("rc_dma_rdata", bus.dma_rdata, 0);
    check("rc_err_sticky", bus.core_err, 1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
